// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 device-to-host frame receiver with a scan-code FIFO
module ps2_keyboard #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [2:0] sync;
  logic [3:0] bitcnt;
  logic [9:0] shift;
  logic [7:0] fifo [FIFO_DEPTH];
  logic [AW-1:0] w_ptr, r_ptr, w_next, r_next;
  logic sample, frame_ok, full, pop, push;
  always_comb begin
    sample = sync[2] & ~sync[1];
    frame_ok = sample && bitcnt == 4'd10 && !shift[0] && ps2_data && ^shift[9:1];
    full = (w_ptr + AW'(1)) == r_ptr;
    pop = ready && !nextdata_n;
    push = frame_ok && (!full || pop);
    w_next = w_ptr + AW'(push);
    r_next = r_ptr + AW'(pop);
    data = fifo[r_ptr];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync <= 3'b111;
      bitcnt <= '0;
      w_ptr <= '0;
      r_ptr <= '0;
      ready <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sync <= {sync[1:0], ps2_clk};
      if (sample) bitcnt <= (bitcnt == 4'd10) ? 4'd0 : bitcnt + 4'd1;
      w_ptr <= w_next;
      r_ptr <= r_next;
      ready <= w_next != r_next;
      overflow <= pop ? 1'b0 : (overflow | (frame_ok & full));
    end
  end
  // frame bits and FIFO storage are never cleared by reset
  always_ff @(posedge clk) begin
    if (sample && bitcnt < 4'd10) shift[bitcnt] <= ps2_data;
    if (push) fifo[w_ptr] <= shift[8:1];
  end
endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: directed and randomized frames checked against a queue model
module tb_ps2_keyboard;
  localparam int DEPTH = 8;
  logic clk = 1'b0, rst = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, nextdata_n = 1'b1;
  logic [7:0] data;
  logic ready, overflow;
  int vectors = 0, miscompares = 0;
  logic [7:0] q[$];
  bit ovf = 1'b0;

  ps2_keyboard #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .data(data), .ready(ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] mk(input logic [7:0] b, input int err);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    if (err == 0) f[9] = ~f[9];
    if (err == 1) f[10] = 1'b0;
    if (err == 2) f[0] = 1'b1;
    return f;
  endfunction

  task automatic model_pop();
    if (q.size() != 0) begin
      void'(q.pop_front());
      ovf = 1'b0;
    end
  endtask

  task automatic send(input logic [10:0] f, input int n, input bit pop_stop);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) ps2_data = f[i];
      repeat (3) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10 && pop_stop) begin
        repeat (2) @(negedge clk);
        nextdata_n = 1'b0;
        model_pop();
        @(negedge clk) nextdata_n = 1'b1;
        repeat (7) @(negedge clk);
      end else repeat (10) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (5) @(negedge clk);
    end
    if (n == 11 && !f[0] && f[10] && ^f[9:1]) begin
      if (q.size() < DEPTH - 1) q.push_back(f[8:1]);
      else ovf = 1'b1;
    end
  endtask

  task automatic pop();
    @(negedge clk) nextdata_n = 1'b0;
    model_pop();
    @(negedge clk) nextdata_n = 1'b1;
  endtask

  task automatic check(input string tag);
    @(negedge clk);
    vectors++;
    assert (ready === (q.size() != 0)) else begin
      miscompares++;
      $error("FAIL %s ready got %b exp %b", tag, ready, q.size() != 0);
    end
    vectors++;
    assert (overflow === ovf) else begin
      miscompares++;
      $error("FAIL %s overflow got %b exp %b", tag, overflow, ovf);
    end
    if (q.size() != 0) begin
      vectors++;
      assert (data === q[0]) else begin
        miscompares++;
        $error("FAIL %s data got %h exp %h", tag, data, q[0]);
      end
    end
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b1;
    check("reset");
    send(mk(8'h1C, 9), 11, 1'b0);
    check("single");
    pop();
    check("single_pop");
    pop();
    check("empty_pop_ignored");
    send(mk(8'h1C, 9), 11, 1'b0);
    send(mk(8'hF0, 9), 11, 1'b0);
    send(mk(8'h1C, 9), 11, 1'b0);
    check("break_0");
    pop(); check("break_1");
    pop(); check("break_2");
    pop(); check("break_3");
    send(mk(8'h1C, 0), 11, 1'b0);
    check("bad_parity");
    send(mk(8'h55, 1), 11, 1'b0);
    check("bad_stop");
    send(mk(8'h32, 9), 11, 1'b0);
    check("after_bad");
    pop();
    for (int i = 1; i <= 8; i++) begin
      send(mk(8'(i), 9), 11, 1'b0);
      check($sformatf("ovf_fill_%0d", i));
    end
    for (int i = 0; i < 7; i++) begin
      pop();
      check($sformatf("ovf_drain_%0d", i));
    end
    send(mk(8'hA7, 9), 11, 1'b0);
    send(mk(8'h3B, 9), 11, 1'b1);
    check("push_pop_same");
    pop();
    check("push_pop_after");
    for (int i = 1; i <= 7; i++) send(mk(8'(8'h40 + i), 9), 11, 1'b0);
    send(mk(8'h77, 9), 11, 1'b1);
    check("full_push_pop");
    while (q.size() != 0) begin pop(); check("full_drain"); end
    send(mk(8'h1C, 9), 11, 1'b0);
    send(mk(8'h99, 9), 5, 1'b0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    q.delete();
    ovf = 1'b0;
    check("mid_reset");
    send(mk(8'h1C, 9), 11, 1'b0);
    check("after_reset");
    for (int it = 0; it < 40; it++) begin
      automatic logic [7:0] b = 8'($urandom);
      automatic int err = int'($urandom_range(0, 6));
      automatic bit ps = ($urandom_range(0, 3) == 0);
      send(mk(b, err), 11, ps);
      check("rand_frame");
      for (int k = int'($urandom_range(0, 2)); k > 0; k--) begin
        pop();
        check("rand_pop");
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
